// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes and filters the PLL lock flag, pulses the PLL reset,
// retries on lock timeout and holds a stretched system reset until lock has been stable.
module pll_lock_supervisor #(
  parameter int LOCK_FILTER    = 1024,
  parameter int RST_STRETCH    = 256,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             locked,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int MAX_A   = (LOCK_TIMEOUT > LOCK_FILTER) ? LOCK_TIMEOUT : LOCK_FILTER;
  localparam int MAX_B   = (RST_STRETCH > PLL_RST_CYCLES) ? RST_STRETCH : PLL_RST_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  // Each state leaves on the edge where the shared counter holds its last in-state value.
  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(RST_STRETCH - 1);
  localparam logic [CNT_W-1:0] SAT_VAL   = '1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_FILTER,
    S_STRETCH,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             pll_rst_q, sys_rst_q, locked_q;
  logic             lock_s;

  assign lock_s = sync_q[1];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    loss_d  = loss_q;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_FILTER;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_PLL_RST;
          if (retry_q != SAT_VAL) retry_d = retry_q + CNT_W'(1);
        end
      end
      S_FILTER: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (cnt_q == FILTER_LAST) state_d = S_STRETCH;
      end
      S_STRETCH: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          if (loss_q != SAT_VAL) loss_d = loss_q + CNT_W'(1);
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = S_PLL_RST;
          if (loss_q != SAT_VAL) loss_d = loss_q + CNT_W'(1);
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they toggle on the same edge as the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      loss_q    <= '0;
      retry_q   <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
      sync_q    <= {sync_q[0], pll_lock};
      pll_rst_q <= (state_d == S_PLL_RST);
      sys_rst_q <= (state_d != S_RUN);
      locked_q  <= (state_d == S_RUN);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign locked      = locked_q;
  assign loss_count  = loss_q;
  assign retry_count = retry_q;

endmodule
